// File: rtl/fx_pkg.sv
// Shared definitions for the fx register bus command master.
// Covers the address layout, the command opcodes and the FSM state encoding.
package fx_pkg;

  localparam int FX_ADDR_W = 22;
  localparam int FX_DEV_W  = 6;

  localparam logic [7:0] OP_WR = 8'h01;
  localparam logic [7:0] OP_RD = 8'h02;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_ADR2  = 4'd1;
  localparam logic [3:0] S_ADR1  = 4'd2;
  localparam logic [3:0] S_ADR0  = 4'd3;
  localparam logic [3:0] S_DATA  = 4'd4;
  localparam logic [3:0] S_WR    = 4'd5;
  localparam logic [3:0] S_RD    = 4'd6;
  localparam logic [3:0] S_RWAIT = 4'd7;
  localparam logic [3:0] S_RSP   = 4'd8;

  typedef enum logic [3:0] {
    ST_IDLE  = S_IDLE,
    ST_ADR2  = S_ADR2,
    ST_ADR1  = S_ADR1,
    ST_ADR0  = S_ADR0,
    ST_DATA  = S_DATA,
    ST_WR    = S_WR,
    ST_RD    = S_RD,
    ST_RWAIT = S_RWAIT,
    ST_RSP   = S_RSP
  } fx_state_e;

endpackage

// File: rtl/fx_byte_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches TIMEOUT-1.
module fx_byte_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_r;

  // cycle counter; clear takes priority so the timer restarts on every byte
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = en & (cnt_r == LAST);

endmodule

// File: rtl/fx_cmd_master.sv
// Host-link byte stream to fx register bus master: parses OP/A2/A1/A0[/D]
// frames into single write or read cycles and returns read bytes on a stream.
module fx_cmd_master
  import fx_pkg::*;
#(
  parameter int TIMEOUT = 1000,
  parameter int ERR_W   = 8
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic [7:0]           cmd_data,
  input  logic                 cmd_vld,
  output logic                 cmd_rdy,
  output logic [7:0]           rsp_data,
  output logic                 rsp_vld,
  input  logic                 rsp_rdy,
  output logic [FX_ADDR_W-1:0] fx_waddr,
  output logic [7:0]           fx_data,
  output logic                 fx_wr,
  output logic [FX_ADDR_W-1:0] fx_raddr,
  output logic                 fx_rd,
  input  logic [7:0]           fx_q,
  output logic                 busy,
  output logic [ERR_W-1:0]     err_cnt
);

  fx_state_e            state_r;
  logic                 op_wr_r;
  logic [FX_ADDR_W-1:0] addr_r;
  logic                 accept_s;
  logic                 wait_s;
  logic                 tmr_clr_s;
  logic                 tmr_exp_s;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(ERR_W-1){1'b0}}, 1'b1};
    end
  endfunction

  assign accept_s = cmd_vld & cmd_rdy;

  // mid-frame states in which the inter-byte timer runs
  always_comb begin
    wait_s = 1'b0;
    case (state_r)
      ST_ADR2, ST_ADR1, ST_ADR0, ST_DATA: wait_s = 1'b1;
      default:                            wait_s = 1'b0;
    endcase
  end

  assign tmr_clr_s = accept_s | ~wait_s | tmr_exp_s;

  fx_byte_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .clr     (tmr_clr_s),
    .en      (wait_s),
    .expire  (tmr_exp_s)
  );

  // frame FSM with all bus and stream outputs registered
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      op_wr_r  <= 1'b0;
      addr_r   <= '0;
      cmd_rdy  <= 1'b0;
      rsp_data <= 8'h00;
      rsp_vld  <= 1'b0;
      fx_waddr <= '0;
      fx_data  <= 8'h00;
      fx_wr    <= 1'b0;
      fx_raddr <= '0;
      fx_rd    <= 1'b0;
      busy     <= 1'b0;
      err_cnt  <= '0;
    end else begin
      fx_wr <= 1'b0;
      fx_rd <= 1'b0;
      // a byte arriving on the expiry cycle wins over the abort
      if (tmr_exp_s && !accept_s) begin
        state_r <= ST_IDLE;
        busy    <= 1'b0;
        err_cnt <= sat_inc(err_cnt);
      end else begin
        case (state_r)
          ST_IDLE: begin
            cmd_rdy <= 1'b1;
            if (accept_s) begin
              if ((cmd_data == OP_WR) || (cmd_data == OP_RD)) begin
                op_wr_r <= (cmd_data == OP_WR);
                state_r <= ST_ADR2;
                busy    <= 1'b1;
              end else begin
                err_cnt <= sat_inc(err_cnt);
              end
            end
          end
          ST_ADR2: begin
            if (accept_s) begin
              addr_r[FX_ADDR_W-1:16] <= cmd_data[FX_DEV_W-1:0];
              state_r                <= ST_ADR1;
            end
          end
          ST_ADR1: begin
            if (accept_s) begin
              addr_r[15:8] <= cmd_data;
              state_r      <= ST_ADR0;
            end
          end
          ST_ADR0: begin
            if (accept_s) begin
              addr_r[7:0] <= cmd_data;
              if (op_wr_r) begin
                state_r <= ST_DATA;
              end else begin
                state_r  <= ST_RD;
                fx_rd    <= 1'b1;
                fx_raddr <= {addr_r[FX_ADDR_W-1:8], cmd_data};
                cmd_rdy  <= 1'b0;
              end
            end
          end
          ST_DATA: begin
            if (accept_s) begin
              state_r  <= ST_WR;
              fx_wr    <= 1'b1;
              fx_waddr <= addr_r;
              fx_data  <= cmd_data;
              cmd_rdy  <= 1'b0;
            end
          end
          ST_WR: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            cmd_rdy <= 1'b1;
          end
          ST_RD: begin
            state_r <= ST_RWAIT;
          end
          ST_RWAIT: begin
            rsp_data <= fx_q;
            rsp_vld  <= 1'b1;
            state_r  <= ST_RSP;
          end
          ST_RSP: begin
            if (rsp_rdy) begin
              rsp_vld <= 1'b0;
              state_r <= ST_IDLE;
              busy    <= 1'b0;
              cmd_rdy <= 1'b1;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            cmd_rdy <= 1'b0;
            rsp_vld <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fx_cmd_master.sv
// Scoreboard bench for fx_cmd_master: frames are predicted from a memory model
// of the slaves, and a monitor compares every strobe and response as it appears.
module tb_fx_cmd_master;
  import fx_pkg::*;

  localparam int TO    = 40;
  localparam int ERR_W = 8;

  logic              clk_sys = 1'b0;
  logic              rst_n;
  logic [7:0]        cmd_data;
  logic              cmd_vld;
  logic              cmd_rdy;
  logic [7:0]        rsp_data;
  logic              rsp_vld;
  logic              rsp_rdy;
  logic [21:0]       fx_waddr;
  logic [7:0]        fx_data;
  logic              fx_wr;
  logic [21:0]       fx_raddr;
  logic              fx_rd;
  logic [7:0]        fx_q;
  logic              busy;
  logic [ERR_W-1:0]  err_cnt;

  always #5 clk_sys = ~clk_sys;

  fx_cmd_master #(.TIMEOUT(TO), .ERR_W(ERR_W)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .cmd_data(cmd_data), .cmd_vld(cmd_vld),
    .cmd_rdy(cmd_rdy), .rsp_data(rsp_data), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .fx_waddr(fx_waddr), .fx_data(fx_data), .fx_wr(fx_wr), .fx_raddr(fx_raddr),
    .fx_rd(fx_rd), .fx_q(fx_q), .busy(busy), .err_cnt(err_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slaves: dev 2 and dev 5, each decoding register pages 0x00xx and 0xA5xx
  function automatic bit slave_hit(input logic [21:0] a);
    return ((a[21:16] == 6'd2) || (a[21:16] == 6'd5)) &&
           ((a[15:8] == 8'h00) || (a[15:8] == 8'hA5));
  endfunction

  function automatic int sidx(input logic [21:0] a);
    return int'({(a[21:16] == 6'd5), (a[15:8] == 8'hA5), a[7:0]});
  endfunction

  logic [7:0] smem [0:1023];

  always @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) smem[i] <= 8'h00;
      fx_q <= 8'h00;
    end else begin
      if (fx_wr && slave_hit(fx_waddr)) smem[sidx(fx_waddr)] <= fx_data;
      if (fx_rd && slave_hit(fx_raddr)) fx_q <= smem[sidx(fx_raddr)];
      else fx_q <= 8'h00;
    end
  end

  // Reference model and scoreboard queues
  typedef struct packed { logic [21:0] a; logic [7:0] d; } wr_t;
  wr_t         wr_q [$];
  logic [21:0] rd_q [$];
  logic [7:0]  rsp_q [$];
  logic [7:0]  ref_mem [logic [21:0]];
  int          ref_err = 0;

  function automatic logic [7:0] ref_read(input logic [21:0] a);
    if (slave_hit(a) && ref_mem.exists(a)) return ref_mem[a];
    return 8'h00;
  endfunction

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Response-ready driver: 0 = always ready, 1 = stalled, 2 = random
  int rdy_mode = 0;
  initial begin
    rsp_rdy = 1'b1;
    forever begin
      @(negedge clk_sys);
      case (rdy_mode)
        1:       rsp_rdy = 1'b0;
        2:       rsp_rdy = 1'($urandom_range(0, 1));
        default: rsp_rdy = 1'b1;
      endcase
    end
  end

  // Monitor
  int cyc = 0, last_acc = -100, rd_cyc = -100;
  bit prev_wr = 0, prev_rd = 0, prev_rv = 0;
  always begin
    @(posedge clk_sys);
    cyc++;
    if (rst_n && cmd_vld && cmd_rdy) last_acc = cyc;
    if (rst_n && rsp_vld && rsp_rdy) begin
      if (rsp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
      else check("rsp_data", rsp_data, rsp_q.pop_front());
    end
    #1;
    if (fx_wr) begin
      wr_t e;
      check("wr_latency", cyc, last_acc);
      check("wr_pulse_width", prev_wr, 0);
      check("wr_rd_exclusive", fx_rd, 0);
      if (wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
      else begin
        e = wr_q.pop_front();
        check("wr_addr", fx_waddr, e.a);
        check("wr_data", fx_data, e.d);
      end
    end
    if (fx_rd) begin
      rd_cyc = cyc;
      check("rd_latency", cyc, last_acc);
      check("rd_pulse_width", prev_rd, 0);
      if (rd_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
      else check("rd_addr", fx_raddr, rd_q.pop_front());
    end
    if (rsp_vld && !prev_rv) check("rsp_latency", cyc, rd_cyc + 2);
    prev_wr = fx_wr;
    prev_rd = fx_rd;
    prev_rv = rsp_vld;
  end

  // Driver helpers
  task automatic send(input logic [7:0] b);
    int k = 0;
    cmd_data = b;
    cmd_vld  = 1'b1;
    while (!cmd_rdy && k < 3000) begin
      @(negedge clk_sys);
      k++;
    end
    if (!cmd_rdy) begin
      check("send_timeout", 32'd0, 32'd1);
      cmd_vld = 1'b0;
    end else begin
      @(negedge clk_sys);
    end
  endtask

  task automatic gap(input int maxg);
    int g = (maxg > 0) ? $urandom_range(0, maxg) : 0;
    if (g > 0) begin
      cmd_vld = 1'b0;
      repeat (g) @(negedge clk_sys);
    end
  endtask

  task automatic send_addr(input logic [21:0] a, input int maxg);
    gap(maxg); send({2'($urandom_range(0, 3)), a[21:16]});
    gap(maxg); send(a[15:8]);
    gap(maxg); send(a[7:0]);
  endtask

  task automatic do_write(input logic [21:0] a, input logic [7:0] d, input int maxg);
    wr_q.push_back({a, d});
    if (slave_hit(a)) ref_mem[a] = d;
    send(OP_WR);
    send_addr(a, maxg);
    gap(maxg); send(d);
    cmd_vld = 1'b0;
  endtask

  task automatic do_read(input logic [21:0] a, input int maxg);
    rd_q.push_back(a);
    rsp_q.push_back(ref_read(a));
    send(OP_RD);
    send_addr(a, maxg);
    cmd_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || rsp_vld || wr_q.size() != 0 || rd_q.size() != 0 || rsp_q.size() != 0) && k < 5000) begin
      @(negedge clk_sys);
      k++;
    end
    if (k >= 5000) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_rdy"}, cmd_rdy, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rsp_vld"}, rsp_vld, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_fx_wr"}, fx_wr, 0);
    check({tag, "_fx_rd"}, fx_rd, 0);
    check({tag, "_waddr"}, fx_waddr, 0);
    check({tag, "_raddr"}, fx_raddr, 0);
    check({tag, "_wdata"}, fx_data, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  initial begin
    logic [7:0]  d0;
    logic [7:0]  b;
    logic [21:0] a;
    bit          stable;
    int          k;
    cmd_vld = 1'b0; cmd_data = 8'h00; rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk_sys);
    check("idle_cmd_rdy", cmd_rdy, 1);

    // Basic write with cmd_vld held, read back through the dev 2 slave
    do_write(22'h020081, 8'h5A, 0);
    do_read(22'h020081, 0);
    wait_idle();
    do_write(22'h020000, 8'h02, 0);
    do_read(22'h020000, 0);
    wait_idle();

    // Timeout after OP,A2
    send(OP_WR); send(8'h02); cmd_vld = 1'b0;
    repeat (TO - 1) @(negedge clk_sys);
    check("to_busy_before", busy, 1);
    @(negedge clk_sys);
    check("to_busy_after", busy, 0);
    check("to_cmd_rdy", cmd_rdy, 1);
    ref_err = sat(ref_err);
    check("to_err_cnt", err_cnt, ref_err);
    // Byte landing exactly on the expiry cycle is accepted
    wr_q.push_back({22'h0200A7, 8'h99});
    ref_mem[22'h0200A7] = 8'h99;
    send(OP_WR); send(8'h02); send(8'h00); cmd_vld = 1'b0;
    repeat (TO - 1) @(negedge clk_sys);
    send(8'hA7); send(8'h99); cmd_vld = 1'b0;
    wait_idle();
    check("to_edge_err_cnt", err_cnt, ref_err);

    // Response back-pressure
    rdy_mode = 1;
    do_read(22'h020081, 0);
    k = 0;
    while (!rsp_vld && k < 20) begin @(negedge clk_sys); k++; end
    d0 = rsp_data;
    check("bp_rsp_data", d0, ref_read(22'h020081));
    stable = 1'b1;
    repeat (50) begin
      @(negedge clk_sys);
      if (!rsp_vld || rsp_data !== d0 || cmd_rdy || !busy) stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    rdy_mode = 0;
    k = 0;
    while (busy && k < 10) begin @(negedge clk_sys); k++; end
    check("bp_done_busy", busy, 0);
    check("bp_done_rsp_vld", rsp_vld, 0);
    check("bp_done_cmd_rdy", cmd_rdy, 1);
    wait_idle();

    // Reset during RWAIT
    do_write(22'h050003, 8'hC3, 0);
    do_read(22'h050003, 0);
    check("rst_mid_in_rd", fx_rd, 1);
    @(negedge clk_sys);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    rsp_q.delete();
    ref_mem.delete();
    ref_err = 0;
    @(negedge clk_sys);
    rst_n = 1'b1;
    @(negedge clk_sys);
    do_write(22'h050003, 8'h3C, 2);
    do_read(22'h050003, 2);
    wait_idle();

    // Randomized frames
    rdy_mode = 2;
    for (int t = 0; t < 60; t++) begin
      k = $urandom_range(0, 9);
      case ($urandom_range(0, 2))
        0:       a[21:16] = 6'd2;
        1:       a[21:16] = 6'd5;
        default: a[21:16] = 6'($urandom_range(0, 63));
      endcase
      case ($urandom_range(0, 2))
        0:       a[15:8] = 8'h00;
        1:       a[15:8] = 8'hA5;
        default: a[15:8] = 8'($urandom_range(0, 255));
      endcase
      a[7:0] = 8'($urandom_range(0, 7));
      if (k == 0) begin
        b = 8'($urandom_range(3, 255));
        send(b); cmd_vld = 1'b0;
        ref_err = sat(ref_err);
        check("rand_bad_op_err", err_cnt, ref_err);
      end else if (k < 5) begin
        do_write(a, 8'($urandom_range(0, 255)), 3);
      end else begin
        do_read(a, 3);
      end
    end
    rdy_mode = 0;
    wait_idle();

    // Bad opcode and error counter saturation
    send(8'h7F); cmd_vld = 1'b0;
    ref_err = sat(ref_err);
    check("bad_op_err_cnt", err_cnt, ref_err);
    check("bad_op_cmd_rdy", cmd_rdy, 1);
    check("bad_op_busy", busy, 0);
    for (int i = 0; i < 256; i++) begin
      send(8'($urandom_range(3, 255)));
      ref_err = sat(ref_err);
    end
    cmd_vld = 1'b0;
    @(negedge clk_sys);
    check("err_saturated", err_cnt, ref_err);
    check("err_all_ones", err_cnt, 8'hFF);

    wait_idle();
    check("wr_q_drained", wr_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
